// File: rtl/stage_mem_pipe.sv
// MEM stage of the 5-stage MIPS pipeline: branch resolve, byte/half/word
// little-endian loads and stores against internal data memory, multi-cycle load stall.
module stage_mem_pipe #(
    parameter int DEPTH   = 1024,
    parameter int MEM_LAT = 2,
    parameter int REG_W   = 5
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             In_valid,
    input  logic             MemWrite,
    input  logic             MemRead,
    input  logic             Branch,
    input  logic             BranchNe,
    input  logic [1:0]       MemSize,
    input  logic             MemUnsigned,
    input  logic             MemtoReg_in,
    input  logic             RegWrite_in,
    input  logic             Zero,
    input  logic [31:0]      ALUResult_in,
    input  logic [31:0]      WriteData_in,
    input  logic [REG_W-1:0] WriteReg_in,
    input  logic [31:0]      BranchTarget_in,
    output logic             PCSrc,
    output logic [31:0]      BranchTarget_out,
    output logic             Stall,
    output logic             Out_valid,
    output logic             MemtoReg_out,
    output logic             RegWrite_out,
    output logic [31:0]      ALUResult_out,
    output logic [31:0]      ReadData_out,
    output logic [REG_W-1:0] WriteReg_out,
    output logic             Misaligned
);

    localparam int         AW        = $clog2(DEPTH);
    localparam logic       LAT_MULTI = (MEM_LAT > 1);
    localparam logic [3:0] CNT_INIT  = LAT_MULTI ? 4'(MEM_LAT - 2) : 4'd0;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] mem [DEPTH];

    logic [AW-1:0] wordIdx_p0;
    logic [1:0]    lane_p0;
    logic          misAddr_p0, misAlign_p0, isLoad_p0, isStore_p0, wbEn_p0;
    logic [3:0]    byteEn_p0;
    logic [31:0]   storeData_p0, rdWord_p0;
    logic          unusedAddrBits;

    function automatic logic [31:0] loadExtend(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic zext);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {lane, 3'b000});
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   return zext ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   return zext ? {16'd0, h} : {{16{h[15]}}, h};
            default: return word;
        endcase
    endfunction

    // Upper address bits above the memory window are deliberately ignored (wrap).
    assign unusedAddrBits = ^(ALUResult_in >> (AW + 2));

    assign wordIdx_p0 = ALUResult_in[AW+1:2];
    assign lane_p0    = ALUResult_in[1:0];
    assign rdWord_p0  = mem[wordIdx_p0];

    always_comb begin
        misAddr_p0   = 1'b0;
        byteEn_p0    = 4'b1111;
        storeData_p0 = WriteData_in;
        case (MemSize)
            2'b00: begin
                byteEn_p0    = 4'b0001 << lane_p0;
                storeData_p0 = {4{WriteData_in[7:0]}};
            end
            2'b01: begin
                misAddr_p0   = lane_p0[0];
                byteEn_p0    = lane_p0[1] ? 4'b1100 : 4'b0011;
                storeData_p0 = {2{WriteData_in[15:0]}};
            end
            default: misAddr_p0 = (lane_p0 != 2'b00);
        endcase
    end

    // A simultaneous read+write request is handled as a store only.
    assign misAlign_p0 = In_valid & (MemRead | MemWrite) & misAddr_p0;
    assign isStore_p0  = In_valid & MemWrite & ~misAlign_p0;
    assign isLoad_p0   = In_valid & MemRead & ~MemWrite & ~misAlign_p0;

    assign PCSrc            = In_valid & Branch & (BranchNe ? ~Zero : Zero);
    assign BranchTarget_out = BranchTarget_in;
    assign Stall            = (state == BUSY) ? (cnt != 4'd0) : (isLoad_p0 & LAT_MULTI);
    assign wbEn_p0          = ~Stall;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else if (state == IDLE) begin
            if (isLoad_p0 && LAT_MULTI) begin
                state <= BUSY;
                cnt   <= CNT_INIT;
            end
        end else if (cnt == 4'd0) begin
            state <= IDLE;
        end else begin
            cnt <= cnt - 4'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (isStore_p0 && state == IDLE) begin
            for (int b = 0; b < 4; b++) begin
                if (byteEn_p0[b]) mem[wordIdx_p0][8*b +: 8] <= storeData_p0[8*b +: 8];
            end
        end
    end

    // MEM/WB boundary: stalled cycles insert a bubble, data registers hold.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Out_valid     <= 1'b0;
            MemtoReg_out  <= 1'b0;
            RegWrite_out  <= 1'b0;
            Misaligned    <= 1'b0;
            ALUResult_out <= 32'd0;
            ReadData_out  <= 32'd0;
            WriteReg_out  <= '0;
        end else if (wbEn_p0) begin
            Out_valid     <= In_valid;
            MemtoReg_out  <= MemtoReg_in;
            RegWrite_out  <= In_valid & RegWrite_in & ~misAlign_p0;
            Misaligned    <= misAlign_p0;
            ALUResult_out <= ALUResult_in;
            ReadData_out  <= isLoad_p0 ? loadExtend(rdWord_p0, MemSize, lane_p0, MemUnsigned) : 32'd0;
            WriteReg_out  <= WriteReg_in;
        end else begin
            Out_valid    <= 1'b0;
            MemtoReg_out <= 1'b0;
            RegWrite_out <= 1'b0;
            Misaligned   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stage_mem_pipe.sv
// Self-checking bench for stage_mem_pipe (DEPTH=1024, MEM_LAT=3): vector table
// with a writeback scoreboard, plus hand sequences for load latency and async reset.
module tb_stage_mem_pipe;
    localparam int DEPTH   = 1024;
    localparam int MEM_LAT = 3;
    localparam int REG_W   = 5;

    logic             Clk = 1'b0;
    logic             Rst_n;
    logic             In_valid, MemWrite, MemRead, Branch, BranchNe, MemUnsigned;
    logic             MemtoReg_in, RegWrite_in, Zero;
    logic [1:0]       MemSize;
    logic [31:0]      ALUResult_in, WriteData_in, BranchTarget_in;
    logic [REG_W-1:0] WriteReg_in;
    logic             PCSrc, Stall, Out_valid, MemtoReg_out, RegWrite_out, Misaligned;
    logic [31:0]      BranchTarget_out, ALUResult_out, ReadData_out;
    logic [REG_W-1:0] WriteReg_out;

    stage_mem_pipe #(.DEPTH(DEPTH), .MEM_LAT(MEM_LAT), .REG_W(REG_W)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .In_valid(In_valid), .MemWrite(MemWrite), .MemRead(MemRead),
        .Branch(Branch), .BranchNe(BranchNe), .MemSize(MemSize), .MemUnsigned(MemUnsigned),
        .MemtoReg_in(MemtoReg_in), .RegWrite_in(RegWrite_in), .Zero(Zero),
        .ALUResult_in(ALUResult_in), .WriteData_in(WriteData_in), .WriteReg_in(WriteReg_in),
        .BranchTarget_in(BranchTarget_in), .PCSrc(PCSrc), .BranchTarget_out(BranchTarget_out),
        .Stall(Stall), .Out_valid(Out_valid), .MemtoReg_out(MemtoReg_out),
        .RegWrite_out(RegWrite_out), .ALUResult_out(ALUResult_out), .ReadData_out(ReadData_out),
        .WriteReg_out(WriteReg_out), .Misaligned(Misaligned)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        vld, rd, wr, br, bne, zero, uns, m2r, rw;
        logic [1:0]  size;
        logic [31:0] addr, wdata;
        logic [4:0]  wreg;
        logic [31:0] expData;
        logic        expMis, expPc;
    } vec_t;

    typedef struct {
        logic [39:0] ctl;
        logic        isLoad;
        logic [31:0] data;
    } sb_t;

    int   checks   = 0;
    int   failures = 0;
    sb_t  sbq[$];
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t vBase();
        vec_t v;
        v = '{vld: 1'b1, rd: 1'b0, wr: 1'b0, br: 1'b0, bne: 1'b0, zero: 1'b0, uns: 1'b0,
              m2r: 1'b0, rw: 1'b0, size: 2'b10, addr: 32'd0, wdata: 32'd0, wreg: 5'd0,
              expData: 32'd0, expMis: 1'b0, expPc: 1'b0};
        return v;
    endfunction

    function automatic vec_t vLd(input logic [1:0] size, input logic uns, input logic [31:0] addr,
                                 input logic [4:0] wreg, input logic [31:0] expData, input logic mis);
        vec_t v = vBase();
        v.rd = 1'b1; v.rw = 1'b1; v.m2r = 1'b1; v.size = size; v.uns = uns;
        v.addr = addr; v.wreg = wreg; v.expData = expData; v.expMis = mis;
        return v;
    endfunction

    function automatic vec_t vSt(input logic [1:0] size, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic mis);
        vec_t v = vBase();
        v.wr = 1'b1; v.size = size; v.addr = addr; v.wdata = wdata; v.expMis = mis;
        return v;
    endfunction

    function automatic vec_t vBr(input logic vld, input logic bne, input logic zero, input logic pc);
        vec_t v = vBase();
        v.vld = vld; v.br = 1'b1; v.bne = bne; v.zero = zero; v.expPc = pc; v.addr = 32'h44;
        return v;
    endfunction

    function automatic vec_t vAlu(input logic [31:0] res, input logic [4:0] wreg);
        vec_t v = vBase();
        v.rw = 1'b1; v.addr = res; v.wreg = wreg;
        return v;
    endfunction

    task automatic idle();
        In_valid = 0; MemWrite = 0; MemRead = 0; Branch = 0; BranchNe = 0; MemUnsigned = 0;
        MemtoReg_in = 0; RegWrite_in = 0; Zero = 0; MemSize = 2'b00;
        ALUResult_in = 0; WriteData_in = 0; WriteReg_in = 0; BranchTarget_in = 0;
    endtask

    task automatic drive(input vec_t v, input int idx);
        In_valid = v.vld; MemRead = v.rd; MemWrite = v.wr; Branch = v.br; BranchNe = v.bne;
        Zero = v.zero; MemUnsigned = v.uns; MemtoReg_in = v.m2r; RegWrite_in = v.rw;
        MemSize = v.size; ALUResult_in = v.addr; WriteData_in = v.wdata; WriteReg_in = v.wreg;
        BranchTarget_in = 32'h0040_0000 + 32'(idx * 4);
    endtask

    // Drive one instruction, hold it through any stall, and score its result.
    task automatic issue(input vec_t v, input int idx);
        int   n;
        int   expStall;
        sb_t  e;
        drive(v, idx);
        e.ctl    = {v.rw & ~v.expMis, v.m2r, v.expMis, v.wreg, v.addr};
        e.isLoad = v.rd & ~v.wr & ~v.expMis;
        e.data   = v.expData;
        expStall = (v.vld && e.isLoad) ? MEM_LAT - 1 : 0;
        if (v.vld) sbq.push_back(e);
        @(negedge Clk);
        chk($sformatf("pcsrc[%0d]", idx), 64'(PCSrc), 64'(v.expPc));
        chk($sformatf("btarget[%0d]", idx), 64'(BranchTarget_out), 64'(BranchTarget_in));
        n = 0;
        while (Stall === 1'b1 && n < 20) begin
            n++;
            @(negedge Clk);
        end
        chk($sformatf("stall_cycles[%0d]", idx), 64'(n), 64'(expStall));
        @(posedge Clk);
        #2 idle();
    endtask

    initial begin : monitor
        sb_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (Rst_n === 1'b1 && Out_valid === 1'b1) begin
                if (sbq.size() == 0) begin
                    chk("wb_unexpected", 64'(Out_valid), 64'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("wb_ctl", 64'({RegWrite_out, MemtoReg_out, Misaligned, WriteReg_out, ALUResult_out}),
                        64'(e.ctl));
                    if (e.isLoad) chk("wb_data", 64'(ReadData_out), 64'(e.data));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        idle();
        Rst_n = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk("reset_ctl", 64'({Out_valid, RegWrite_out, MemtoReg_out, Misaligned, WriteReg_out}), 64'd0);
        chk("reset_data", 64'({ALUResult_out, ReadData_out}), 64'd0);
        chk("reset_stall", 64'(Stall), 64'd0);
        #2 Rst_n = 1'b1;
        @(posedge Clk);
        #2;

        tbl.push_back(vSt(2'b10, 32'h10, 32'h80FF1234, 1'b0));
        tbl.push_back(vLd(2'b00, 1'b0, 32'h11, 5'd3, 32'h00000012, 1'b0));
        tbl.push_back(vLd(2'b00, 1'b0, 32'h13, 5'd4, 32'hFFFFFF80, 1'b0));
        tbl.push_back(vLd(2'b00, 1'b1, 32'h13, 5'd5, 32'h00000080, 1'b0));
        tbl.push_back(vLd(2'b01, 1'b0, 32'h12, 5'd6, 32'hFFFF80FF, 1'b0));
        tbl.push_back(vLd(2'b01, 1'b1, 32'h12, 5'd7, 32'h000080FF, 1'b0));
        tbl.push_back(vLd(2'b10, 1'b0, 32'h10, 5'd8, 32'h80FF1234, 1'b0));
        tbl.push_back(vLd(2'b10, 1'b0, 32'h06, 5'd9, 32'h0, 1'b1));
        tbl.push_back(vSt(2'b10, 32'h04, 32'h11223344, 1'b0));
        tbl.push_back(vSt(2'b01, 32'h03, 32'h0000BEEF, 1'b1));
        tbl.push_back(vLd(2'b10, 1'b0, 32'h04, 5'd10, 32'h11223344, 1'b0));
        tbl.push_back(vSt(2'b10, 32'h20, 32'h00000000, 1'b0));
        tbl.push_back(vSt(2'b00, 32'h20, 32'h123456AB, 1'b0));
        tbl.push_back(vLd(2'b10, 1'b0, 32'h20, 5'd11, 32'h000000AB, 1'b0));
        tbl.push_back(vSt(2'b01, 32'h22, 32'h0000CAFE, 1'b0));
        tbl.push_back(vLd(2'b10, 1'b0, 32'h20, 5'd12, 32'hCAFE00AB, 1'b0));
        tbl.push_back(vSt(2'b10, 32'h1000, 32'hDEADBEEF, 1'b0));
        tbl.push_back(vLd(2'b10, 1'b0, 32'h0, 5'd13, 32'hDEADBEEF, 1'b0));
        tbl.push_back(vLd(2'b10, 1'b0, 32'h2000, 5'd14, 32'hDEADBEEF, 1'b0));
        tbl.push_back(vBr(1'b1, 1'b0, 1'b1, 1'b1));
        tbl.push_back(vBr(1'b1, 1'b1, 1'b1, 1'b0));
        tbl.push_back(vBr(1'b1, 1'b1, 1'b0, 1'b1));
        tbl.push_back(vBr(1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(vBr(1'b0, 1'b0, 1'b1, 1'b0));
        v = vSt(2'b10, 32'h30, 32'h5555AAAA, 1'b0);
        v.rd = 1'b1;
        tbl.push_back(v);
        tbl.push_back(vLd(2'b10, 1'b0, 32'h30, 5'd15, 32'h5555AAAA, 1'b0));
        tbl.push_back(vAlu(32'h12345678, 5'd16));
        tbl.push_back(vLd(2'b00, 1'b0, 32'h31, 5'd17, 32'hFFFFFFAA, 1'b0));

        for (int i = 0; i < tbl.size(); i++) issue(tbl[i], i);

        // Load latency: presented in cycle 0, writeback visible in cycle 3 only.
        drive(vLd(2'b10, 1'b0, 32'h10, 5'd18, 32'h80FF1234, 1'b0), 100);
        sbq.push_back('{ctl: {1'b1, 1'b1, 1'b0, 5'd18, 32'h10}, isLoad: 1'b1, data: 32'h80FF1234});
        @(negedge Clk); chk("lat_stall_c0", 64'(Stall), 64'd1);
        @(posedge Clk); #1 chk("lat_valid_c1", 64'(Out_valid), 64'd0);
        @(negedge Clk); chk("lat_stall_c1", 64'(Stall), 64'd1);
        @(posedge Clk); #1 chk("lat_valid_c2", 64'(Out_valid), 64'd0);
        @(negedge Clk); chk("lat_stall_c2", 64'(Stall), 64'd0);
        @(posedge Clk); #1 chk("lat_valid_c3", 64'(Out_valid), 64'd1);
        chk("lat_data_c3", 64'(ReadData_out), 64'h80FF1234);
        #1 idle();
        @(posedge Clk); #1 chk("lat_valid_c4", 64'(Out_valid), 64'd0);

        // Asynchronous reset in the middle of a BUSY load aborts it.
        #1 drive(vLd(2'b10, 1'b0, 32'h14, 5'd19, 32'h0, 1'b0), 101);
        @(negedge Clk); chk("rst_busy_stall", 64'(Stall), 64'd1);
        @(posedge Clk);
        #3 Rst_n = 1'b0;
        #1;
        chk("rst_async_ctl", 64'({Out_valid, RegWrite_out, MemtoReg_out, Misaligned, WriteReg_out}), 64'd0);
        chk("rst_async_data", 64'({ALUResult_out, ReadData_out}), 64'd0);
        idle();
        @(negedge Clk);
        #2 Rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge Clk);
            #1;
            chk($sformatf("rst_no_wb[%0d]", c), 64'({Out_valid, RegWrite_out}), 64'd0);
            chk($sformatf("rst_idle_stall[%0d]", c), 64'(Stall), 64'd0);
        end

        repeat (6) @(posedge Clk);
        #2 chk("sb_drain", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
